// File: rtl/countdown_ctrl_pkg.sv
// countdown_ctrl_pkg
//   Shared definitions for the countdown timer control block: the state
//   encoding that is also presented on the STATE output, and a small helper
//   used by the FSM.
package countdown_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // True when any of the three button edges is present this cycle.
  function automatic logic any_edge(input logic a, input logic b, input logic c);
    return a | b | c;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if
//   Groups the signals between the countdown controller, the debounced
//   buttons, the 1 Hz strobe and the MM:SS counter chain.
//   master : environment side (drives tick, buttons and chain status)
//   slave  : controller side (drives chain enables, clear, alarm, blink, state)
//   Signals:
//     TICK        1 Hz strobe, one clock wide
//     BTN_START   debounced start/stop level
//     BTN_MIN     debounced minute-set / abort level
//     BTN_SEC     debounced second-set / abort level
//     ZERO        chain reads 00:00
//     SEC_BORROW  carry-out of the seconds stage
//     SEC_CE      enable to the seconds stage
//     MIN_CE      enable to the minutes stage
//     CNT_CLR     one-cycle reload pulse to the chain
//     ALARM       alarm indicator
//     BLINK       display blink enable
//     STATE       current controller state
interface countdown_ctrl_if;
  import countdown_ctrl_pkg::*;

  logic               TICK;
  logic               BTN_START;
  logic               BTN_MIN;
  logic               BTN_SEC;
  logic               ZERO;
  logic               SEC_BORROW;
  logic               SEC_CE;
  logic               MIN_CE;
  logic               CNT_CLR;
  logic               ALARM;
  logic               BLINK;
  logic [STATE_W-1:0] STATE;

  modport master (
    output TICK, BTN_START, BTN_MIN, BTN_SEC, ZERO, SEC_BORROW,
    input  SEC_CE, MIN_CE, CNT_CLR, ALARM, BLINK, STATE
  );

  modport slave (
    input  TICK, BTN_START, BTN_MIN, BTN_SEC, ZERO, SEC_BORROW,
    output SEC_CE, MIN_CE, CNT_CLR, ALARM, BLINK, STATE
  );

endinterface

// File: rtl/countdown_ctrl_edge_det.sv
// countdown_ctrl_edge_det
//   Rising-edge detector for one debounced button level.
//   Ports:
//     CLK   system clock
//     CLR   synchronous active-high reset
//     D     button level
//     RISE  high in the first cycle D is seen high (combinational)
//   The history register resets to 1 so a button held through reset does
//   not produce an edge when reset releases.
module countdown_ctrl_edge_det (
  input  logic CLK,
  input  logic CLR,
  input  logic D,
  output logic RISE
);

  logic prev_q;

  always_ff @(posedge CLK) begin
    if (CLR) prev_q <= 1'b1;
    else     prev_q <= D;
  end

  assign RISE = D & ~prev_q;

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Control FSM for the MM:SS countdown timer. Gates the 1 Hz tick into the
//   seconds stage, routes the seconds borrow into the minutes stage, turns
//   button presses into single set pulses, pauses/resumes, raises the alarm
//   at 00:00 and reloads the chain.
//   Ports:
//     CLK   system clock
//     CLR   synchronous active-high reset
//     bus   countdown_ctrl_if.slave (tick, buttons, chain status in;
//           chain enables, clear, alarm, blink, state out)
//   Parameter:
//     ALARM_SECS  ticks the alarm stays up before returning to IDLE (>= 1)
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic             CLK,
  input  logic             CLR,
  countdown_ctrl_if.slave  bus
);

  localparam int                ACNT_W    = $clog2(ALARM_SECS + 1);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);

  state_t            state_q, state_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              alarm_q, alarm_d;
  logic              blink_q, blink_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic              sec_ce, min_ce;
  logic              start_e, min_e, sec_e;

  countdown_ctrl_edge_det u_start (.CLK(CLK), .CLR(CLR), .D(bus.BTN_START), .RISE(start_e));
  countdown_ctrl_edge_det u_min   (.CLK(CLK), .CLR(CLR), .D(bus.BTN_MIN),   .RISE(min_e));
  countdown_ctrl_edge_det u_sec   (.CLK(CLK), .CLR(CLR), .D(bus.BTN_SEC),   .RISE(sec_e));

  // State and registered outputs; reset reloads the chain via CNT_CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      cnt_clr_q <= 1'b1;
      alarm_q   <= 1'b0;
      blink_q   <= 1'b0;
      acnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= cnt_clr_d;
      alarm_q   <= alarm_d;
      blink_q   <= blink_d;
      acnt_q    <= acnt_d;
    end
  end

  // Next state, registered-output next values and zero-latency chain enables.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    blink_d   = 1'b0;
    acnt_d    = acnt_q;
    sec_ce    = 1'b0;
    min_ce    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        min_ce = min_e;
        sec_ce = sec_e;
        acnt_d = '0;
        if (start_e && !bus.ZERO) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Masking with ZERO stops the chain from wrapping past 00:00.
        sec_ce = bus.TICK & ~bus.ZERO;
        min_ce = bus.SEC_BORROW & ~bus.ZERO;
        if (bus.ZERO) begin
          state_d = ST_ALARM;
          acnt_d  = '0;
        end else if (start_e) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_e) begin
          state_d = ST_RUN;
        end else if (min_e | sec_e) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else begin
          blink_d = blink_q ^ bus.TICK;
        end
      end
      ST_ALARM: begin
        if (any_edge(start_e, min_e, sec_e)) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
          acnt_d    = '0;
        end else if (bus.TICK) begin
          if (acnt_q == ACNT_LAST) begin
            state_d   = ST_IDLE;
            cnt_clr_d = 1'b1;
            acnt_d    = '0;
          end else begin
            acnt_d = acnt_q + ACNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    alarm_d = (state_d == ST_ALARM);
  end

  // Combinational enables are dropped while reset is asserted.
  assign bus.SEC_CE  = sec_ce & ~CLR;
  assign bus.MIN_CE  = min_ce & ~CLR;
  assign bus.CNT_CLR = cnt_clr_q;
  assign bus.ALARM   = alarm_q;
  assign bus.BLINK   = blink_q;
  assign bus.STATE   = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  localparam int ALARM_SECS = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_ALARM = 2'd3;

  logic CLK;
  logic CLR;
  int   checks = 0;
  int   errors = 0;

  countdown_ctrl_if bus();

  countdown_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural MM:SS chain driven by the controller's enables.
  int mm = 0, ss = 2;
  int init_mm = 0, init_ss = 2;
  assign bus.ZERO       = (mm == 0) && (ss == 0);
  assign bus.SEC_BORROW = (bus.SEC_CE === 1'b1) && (ss == 0);
  always @(posedge CLK) begin
    if (bus.CNT_CLR === 1'b1) begin
      mm <= init_mm;
      ss <= init_ss;
    end else begin
      if (bus.SEC_CE === 1'b1) ss <= (ss == 0) ? 59 : ss - 1;
      if (bus.MIN_CE === 1'b1) mm <= (mm == 0) ? 99 : mm - 1;
    end
  end

  // Reference model of the controller's observable behaviour.
  logic [1:0] m_state = S_IDLE;
  bit         m_alarm = 0, m_blink = 0, m_clr = 1;
  int         m_aticks = 0;
  bit         m_pc = 1, m_pm = 1, m_ps = 1;
  logic [1:0] n_state;
  bit         n_alarm, n_blink, n_clr, n_pc, n_pm, n_ps;
  int         n_aticks;
  bit         e_sec, e_min;
  logic [6:0] exp_vec;
  logic [6:0] dut_vec;
  assign dut_vec = {bus.STATE, bus.ALARM, bus.BLINK, bus.CNT_CLR, bus.SEC_CE, bus.MIN_CE};

  task automatic model_eval();
    bit ec, em, es, z, t;
    z  = bus.ZERO;
    t  = bus.TICK;
    ec = bus.BTN_START && !m_pc;
    em = bus.BTN_MIN   && !m_pm;
    es = bus.BTN_SEC   && !m_ps;
    e_sec = 0; e_min = 0;
    n_state = m_state; n_clr = 0; n_blink = 0; n_aticks = m_aticks;
    n_pc = bus.BTN_START; n_pm = bus.BTN_MIN; n_ps = bus.BTN_SEC;
    if (CLR) begin
      n_state = S_IDLE; n_clr = 1; n_aticks = 0;
      n_pc = 1; n_pm = 1; n_ps = 1;
    end else begin
      case (m_state)
        S_IDLE: begin
          e_min = em; e_sec = es;
          if (ec && !z) n_state = S_RUN;
        end
        S_RUN: begin
          e_sec = t && !z;
          e_min = bus.SEC_BORROW && !z;
          if (z) begin n_state = S_ALARM; n_aticks = 0; end
          else if (ec) n_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (ec) n_state = S_RUN;
          else if (em || es) begin n_state = S_IDLE; n_clr = 1; end
          else n_blink = m_blink ^ t;
        end
        default: begin
          if (ec || em || es) begin n_state = S_IDLE; n_clr = 1; end
          else if (t) begin
            n_aticks = m_aticks + 1;
            if (n_aticks == ALARM_SECS) begin n_state = S_IDLE; n_clr = 1; end
          end
        end
      endcase
    end
    n_alarm = (n_state == S_ALARM);
    exp_vec = {m_state, m_alarm, m_blink, m_clr, e_sec, e_min};
  endtask

  task automatic model_commit();
    m_state = n_state; m_alarm = n_alarm; m_blink = n_blink; m_clr = n_clr;
    m_aticks = n_aticks; m_pc = n_pc; m_pm = n_pm; m_ps = n_ps;
  endtask

  // Drive one cycle's inputs (just after the edge) and evaluate the model mid-cycle.
  task automatic cyc(input bit clr, input bit tick, input bit bs, input bit bm, input bit bsec);
    CLR = clr; bus.TICK = tick; bus.BTN_START = bs; bus.BTN_MIN = bm; bus.BTN_SEC = bsec;
    #4;
    model_eval();
  endtask

  task automatic advance();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic do_reset(input bit hold_start, input int mmv, input int ssv);
    init_mm = mmv; init_ss = ssv;
    cyc(1, 0, hold_start, 0, 0);
    advance();
  endtask

  task automatic to_run(input int mmv, input int ssv);
    do_reset(0, mmv, ssv);
    cyc(0, 0, 0, 0, 0); advance();
    cyc(0, 0, 1, 0, 0); advance();
    cyc(0, 0, 0, 0, 0); advance();
  endtask

  task automatic goto_alarm();
    bit got = 0;
    to_run(0, 1);
    cyc(0, 1, 0, 0, 0); advance();
    for (int k = 0; k < 4 && !got; k++) begin
      cyc(0, 0, 0, 0, 0);
      got = (bus.STATE === S_ALARM);
      advance();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL goto_alarm state got %0d want 3", bus.STATE); end
  endtask

  task automatic test_reset();
    do_reset(1, 0, 2);
    do_reset(1, 0, 2);
    cyc(0, 0, 1, 0, 0);
    checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_vec0 got %b want %b", dut_vec, exp_vec); end
    checks++; if (bus.CNT_CLR !== 1'b1 || bus.STATE !== S_IDLE || bus.ALARM !== 1'b0 || bus.BLINK !== 1'b0) begin
      errors++; $display("FAIL reset_values clr=%b st=%0d al=%b bl=%b want 1 0 0 0", bus.CNT_CLR, bus.STATE, bus.ALARM, bus.BLINK);
    end
    advance();
    cyc(0, 0, 1, 0, 0);
    checks++; if (bus.CNT_CLR !== 1'b0) begin errors++; $display("FAIL reset_clr_fall got %b want 0", bus.CNT_CLR); end
    advance();
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.STATE !== S_IDLE) begin errors++; $display("FAIL reset_held_no_edge state got %0d want 0", bus.STATE); end
    advance();
    cyc(0, 0, 1, 0, 0);
    checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_press got %b want %b", dut_vec, exp_vec); end
    advance();
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.STATE !== S_RUN) begin errors++; $display("FAIL reset_start_run state got %0d want 1", bus.STATE); end
    advance();
  endtask

  task automatic test_idle_set();
    bit bm_seq [12];
    bit bs_seq [12];
    int n_min = 0, n_sec = 0, n_both = 0;
    bm_seq = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    bs_seq = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    do_reset(0, 0, 2);
    cyc(0, 0, 0, 0, 0); advance();
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, bm_seq[i], bs_seq[i]);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL idle_set cycle %0d got %b want %b", i, dut_vec, exp_vec); end
      if (bus.MIN_CE === 1'b1) n_min++;
      if (bus.SEC_CE === 1'b1) n_sec++;
      if (bus.MIN_CE === 1'b1 && bus.SEC_CE === 1'b1) n_both++;
      advance();
    end
    checks++; if (n_min != 3) begin errors++; $display("FAIL idle_min_pulses got %0d want 3", n_min); end
    checks++; if (n_sec != 1) begin errors++; $display("FAIL idle_sec_pulses got %0d want 1", n_sec); end
    checks++; if (n_both != 1) begin errors++; $display("FAIL idle_coincident got %0d want 1", n_both); end
  endtask

  task automatic test_run_zero();
    int n_sec = 0, i_zero = -1, i_alarm = -1, late_ce = 0;
    to_run(0, 2);
    for (int i = 0; i < 12; i++) begin
      cyc(0, (i % 3 == 0) || (i == 4), 0, 0, 0);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL run_zero cycle %0d got %b want %b", i, dut_vec, exp_vec); end
      if (bus.SEC_CE === 1'b1) n_sec++;
      if (bus.SEC_CE === 1'b1 && i_zero >= 0) late_ce++;
      if (bus.ZERO === 1'b1 && i_zero < 0) i_zero = i;
      if (bus.STATE === S_ALARM && i_alarm < 0) i_alarm = i;
      advance();
    end
    checks++; if (n_sec != 2) begin errors++; $display("FAIL run_sec_ce_count got %0d want 2", n_sec); end
    checks++; if (late_ce != 0) begin errors++; $display("FAIL run_no_wrap late SEC_CE got %0d want 0", late_ce); end
    checks++; if (i_zero != 4 || i_alarm != 5) begin
      errors++; $display("FAIL run_alarm_latency zero@%0d alarm@%0d want 4 and 5", i_zero, i_alarm);
    end
    checks++; if (bus.STATE !== S_ALARM || bus.ALARM !== 1'b1) begin
      errors++; $display("FAIL run_alarm_hold st=%0d al=%b want 3 1", bus.STATE, bus.ALARM);
    end
  endtask

  task automatic test_pause();
    int nt = 0;
    to_run(0, 5);
    cyc(0, 0, 1, 0, 0); advance();
    cyc(0, 0, 0, 0, 0); advance();
    for (int i = 0; i < 15; i++) begin
      cyc(0, i % 3 == 1, 0, 0, 0);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL pause cycle %0d got %b want %b", i, dut_vec, exp_vec); end
      checks++; if (bus.STATE !== S_PAUSE || bus.SEC_CE !== 1'b0 || bus.BLINK !== nt[0]) begin
        errors++; $display("FAIL pause_blink cycle %0d st=%0d ce=%b bl=%b want 2 0 %b", i, bus.STATE, bus.SEC_CE, bus.BLINK, nt[0]);
      end
      if (i % 3 == 1) nt++;
      advance();
    end
    cyc(0, 0, 1, 0, 0);
    checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL pause_resume_press got %b want %b", dut_vec, exp_vec); end
    advance();
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.STATE !== S_RUN || bus.BLINK !== 1'b0) begin
      errors++; $display("FAIL pause_resume st=%0d bl=%b want 1 0", bus.STATE, bus.BLINK);
    end
    advance();
  endtask

  task automatic test_alarm();
    goto_alarm();
    for (int t = 0; t < 3; t++) begin
      cyc(0, 1, 0, 0, 0);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL alarm_tick %0d got %b want %b", t, dut_vec, exp_vec); end
      advance();
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (t < 2) begin
        if (bus.STATE !== S_ALARM || bus.ALARM !== 1'b1 || bus.CNT_CLR !== 1'b0) begin
          errors++; $display("FAIL alarm_hold tick %0d st=%0d al=%b clr=%b want 3 1 0", t, bus.STATE, bus.ALARM, bus.CNT_CLR);
        end
      end else if (bus.STATE !== S_IDLE || bus.ALARM !== 1'b0 || bus.CNT_CLR !== 1'b1) begin
        errors++; $display("FAIL alarm_timeout st=%0d al=%b clr=%b want 0 0 1", bus.STATE, bus.ALARM, bus.CNT_CLR);
      end
      advance();
      cyc(0, 0, 0, 0, 0);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL alarm_gap %0d got %b want %b", t, dut_vec, exp_vec); end
      advance();
    end
    goto_alarm();
    cyc(0, 1, 0, 0, 0); advance();
    cyc(0, 0, 0, 0, 1);
    checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL alarm_abort_press got %b want %b", dut_vec, exp_vec); end
    advance();
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.STATE !== S_IDLE || bus.ALARM !== 1'b0 || bus.CNT_CLR !== 1'b1) begin
      errors++; $display("FAIL alarm_abort st=%0d al=%b clr=%b want 0 0 1", bus.STATE, bus.ALARM, bus.CNT_CLR);
    end
    advance();
  endtask

  task automatic test_simultaneous();
    to_run(0, 1);
    cyc(0, 1, 0, 0, 0);
    checks++; if (bus.SEC_CE !== 1'b1) begin errors++; $display("FAIL simul_last_tick SEC_CE got %b want 1", bus.SEC_CE); end
    advance();
    cyc(0, 0, 1, 0, 0);
    checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL simul_zero_start got %b want %b", dut_vec, exp_vec); end
    advance();
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.STATE !== S_ALARM) begin errors++; $display("FAIL simul_zero_priority state got %0d want 3", bus.STATE); end
    advance();
    cyc(1, 0, 0, 0, 0);
    checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL simul_clr_cycle got %b want %b", dut_vec, exp_vec); end
    advance();
    cyc(0, 0, 0, 0, 0);
    checks++; if (bus.STATE !== S_IDLE || bus.ALARM !== 1'b0 || bus.CNT_CLR !== 1'b1) begin
      errors++; $display("FAIL simul_clr_in_alarm st=%0d al=%b clr=%b want 0 0 1", bus.STATE, bus.ALARM, bus.CNT_CLR);
    end
    advance();
  endtask

  task automatic test_random();
    bit bs = 0, bm = 0, bx = 0, clr;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bs = !bs;
      if ($urandom_range(0, 9) == 0) bm = !bm;
      if ($urandom_range(0, 9) == 0) bx = !bx;
      clr = ($urandom_range(0, 299) == 0);
      if (clr) begin init_mm = $urandom_range(0, 1); init_ss = $urandom_range(0, 3); end
      cyc(clr, $urandom_range(0, 3) == 0, bs, bm, bx);
      checks++; if (dut_vec !== exp_vec) begin errors++; $display("FAIL random cycle %0d got %b want %b", i, dut_vec, exp_vec); end
      advance();
    end
  endtask

  initial begin
    CLR = 1'b1;
    bus.TICK = 1'b0; bus.BTN_START = 1'b0; bus.BTN_MIN = 1'b0; bus.BTN_SEC = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_idle_set();
    test_run_zero();
    test_pause();
    test_alarm();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Control FSM for the countdown timer. It sequences the MM:SS down-counter chain: it gates the 1 Hz tick into the seconds stage and routes the seconds borrow into the minutes stage. It also turns button presses into single set-pulses, pauses and resumes the count, raises the alarm at 00:00 and re-initialises the chain. It sits between the debounced button inputs and the counter chain feeding the display.

## Interface
- ALARM_SECS, 10: tick count the alarm stays active before auto-return to IDLE; legal range ≥1.
- CLK  in  1  system clock.
- CLR  in  1  synchronous, active-high reset.
- TICK  in  1  1 Hz strobe, one CLK cycle wide.
- BTN_START  in  1  debounced start/stop level.
- BTN_MIN  in  1  debounced minute-set / abort level.
- BTN_SEC  in  1  debounced second-set / abort level.
- ZERO  in  1  counter chain reads 00:00.
- SEC_BORROW  in  1  CEO of the seconds stage.
- SEC_CE  out  1  CE to the seconds stage.
- MIN_CE  out  1  CE to the minutes stage.
- CNT_CLR  out  1  one-cycle clear pulse to the chain. Restores the chain's INIT_VAL.
- ALARM  out  1  alarm indicator.
- BLINK  out  1  display blink enable, toggles in PAUSE.
- STATE  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.

## Operation
- Edge detection:
  - Each button has a prev register. Edge = BTN & ~prev, combinational, in the cycle the level is first seen high.
  - prev resets to 1, so a button held through reset produces no edge.
- IDLE:
  - BTN_MIN edge → MIN_CE=1 for that cycle. BTN_SEC edge → SEC_CE=1 for that cycle. Both edges in the same cycle → both pulses.
  - BTN_START edge with ZERO=0 → RUN.
  - BTN_START edge with ZERO=1 → no change.
- RUN:
  - SEC_CE = TICK & ~ZERO; MIN_CE = SEC_BORROW & ~ZERO. No wrap past 00:00.
  - ZERO=1 → ALARM. BTN_START edge → PAUSE. ZERO has priority over a simultaneous START edge.
  - BTN_MIN and BTN_SEC are ignored.
- PAUSE:
  - SEC_CE=MIN_CE=0. BLINK toggles on each TICK.
  - BTN_START edge → RUN.
  - BTN_MIN or BTN_SEC edge → IDLE with CNT_CLR pulse (abort). START has priority over abort.
- ALARM:
  - ALARM=1. Alarm counter (width $clog2(ALARM_SECS+1)) is cleared on entry and increments on TICK.
  - TICK while count==ALARM_SECS-1 → IDLE with CNT_CLR pulse.
  - Any button edge → IDLE with CNT_CLR pulse, immediately.
- BLINK is 0 in every state except PAUSE and is forced to 0 on leaving PAUSE.
- CLR mid-operation: state → IDLE in the next cycle. Any in-flight pulse is dropped; the alarm counter is cleared.

## Timing
- Reset values: STATE=IDLE, CNT_CLR=1, ALARM=0, BLINK=0, prev regs=1, alarm counter=0.
- CNT_CLR=1 initialises the chain in the first cycle after reset and falls to 0 in the following cycle.
- SEC_CE and MIN_CE are combinational, asserted in the same cycle as TICK, SEC_BORROW or the edge. Zero latency, to match the chain's CE chaining.
- STATE, ALARM, BLINK and CNT_CLR are registered.
  - Edge or ZERO condition at cycle n → new STATE visible at n+1.
  - CNT_CLR is high exactly in cycle n+1, for one cycle.
- ALARM rises in the cycle after ZERO is first seen in RUN. It falls in the cycle after the exit condition.
- A level held high produces exactly one edge. Re-arming requires the level to go low for at least one cycle.

## Structure
- Shared include timer_defs.vh holds:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM.
  - STATE_W=2.
- Sub-module edge_det (CLK, CLR, D, RISE) has the prev register with reset value 1. It is instantiated three times.
- The FSM uses one registered state, with next-state and output logic in separate blocks.

## Test plan
- Reset with BTN_START held high, then release and press again. Required: no edge while held; CNT_CLR high for exactly one cycle after reset; STATE=0; after the new press, STATE=1 one cycle later.
- IDLE: pulse BTN_MIN 3 times and BTN_SEC once with the same rising cycle as the third BTN_MIN. Required: MIN_CE pulses exactly 3 times, one cycle each; SEC_CE exactly once, coincident with the third MIN_CE.
- RUN from 00:02 with a behavioural chain model. Required:
  - SEC_CE on each TICK.
  - STATE=3 and ALARM=1 one cycle after ZERO.
  - No SEC_CE on any later TICK, so the chain never wraps.
- RUN, press START → PAUSE. Required: STATE=2; BLINK toggles on 4 TICKs (0→1→0→1→0); SEC_CE stays 0. Press START again → STATE=1 and BLINK=0.
- ALARM with ALARM_SECS=3. Required:
  - After the 3rd TICK: STATE=0, CNT_CLR one-cycle pulse, ALARM=0.
  - Repeat and press BTN_SEC after 1 TICK: same exit the next cycle.
- Simultaneous: START edge in the same cycle ZERO rises in RUN → STATE=3, not 2. CLR asserted in ALARM → STATE=0, ALARM=0, CNT_CLR=1 in the next cycle.
